imem_arbiter: RTL and testbench

Arbiter and sequencer for the single-port instruction memory behind the fetch stage. It shares the memory between the fetch stage's instruction reads and a program loader/debug port that reads and writes. The grant policy is loader-priority with a bounded burst so fetch cannot starve. It squashes fetch read data in flight when the memory stage signals a taken branch (ME_BRT), and drives F_STALL so fetch holds its PC while it is not granted.

---
 rtl/imem_arbiter.sv | 156 +++++++++++++++
 tb/tb_imem_arbiter.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/imem_arbiter.sv
// imem_arbiter: shares the single-port instruction memory between fetch reads
// and a loader/debug port (loader priority, bounded burst), squashes fetch data
// on a taken branch, and tracks which requester owns the 1-cycle read response.
// Latency: grants are combinational; read data returns exactly 1 cycle after grant.
// Backpressure: a requester holds REQ until its GNT; fetch sees F_STALL while waiting.
// Optional feature macro: IMEM_ARB_LOADER_EN (undefined = fetch-only arbiter).
module imem_arbiter #(
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 32,
  parameter int LD_MAX_BURST = 4
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              F_REQ,
  input  logic [ADDR_W-1:0] F_ADDR,
  output logic              F_GNT,
  output logic              F_STALL,
  output logic              F_RVALID,
  output logic [DATA_W-1:0] F_RDATA,
  input  logic              ME_BRT,
  input  logic              L_REQ,
  input  logic              L_WE,
  input  logic [ADDR_W-1:0] L_ADDR,
  input  logic [DATA_W-1:0] L_WDATA,
  output logic              L_GNT,
  output logic              L_RVALID,
  output logic [DATA_W-1:0] L_RDATA,
  output logic              M_EN,
  output logic              M_WE,
  output logic [ADDR_W-3:0] M_ADDR,
  output logic [DATA_W-1:0] M_WDATA,
  input  logic [DATA_W-1:0] M_RDATA
);

`ifdef IMEM_ARB_LOADER_EN
  typedef enum logic [1:0] {S_IDLE, S_FRD, S_LRD} owner_e;
  localparam logic [3:0] LC_MAX = 4'(LD_MAX_BURST);
  logic [3:0]        r_burst_cnt;
  logic [3:0]        w_burst_nxt;
  logic [DATA_W-1:0] r_m_wdata;
`else
  typedef enum logic {S_IDLE, S_FRD} owner_e;
`endif

  owner_e            r_owner;
  owner_e            w_owner_nxt;
  logic              r_squash;
  logic              w_squash_nxt;
  logic              w_f_gnt;
  logic              w_l_gnt;
  logic [ADDR_W-3:0] r_m_addr;
  logic              w_unused;

`ifdef IMEM_ARB_LOADER_EN
  assign w_unused = ^{F_ADDR[1:0], L_ADDR[1:0]};
`else
  assign w_unused = ^{F_ADDR[1:0], L_REQ, L_WE, L_ADDR, L_WDATA};
`endif

  // Grant selection: loader wins until it has used its burst while fetch waits
  always_comb begin
    w_f_gnt = 1'b0;
    w_l_gnt = 1'b0;
`ifdef IMEM_ARB_LOADER_EN
    if (L_REQ && (!F_REQ || (r_burst_cnt < LC_MAX))) begin
      w_l_gnt = 1'b1;
    end else if (F_REQ) begin
      w_f_gnt = 1'b1;
    end
`else
    w_f_gnt = F_REQ;
`endif
  end

  // Next owner of the response slot, squash flag and burst count
  always_comb begin
    w_owner_nxt  = S_IDLE;
    w_squash_nxt = w_f_gnt & ME_BRT;
    if (w_f_gnt) begin
      w_owner_nxt = S_FRD;
    end
`ifdef IMEM_ARB_LOADER_EN
    else if (w_l_gnt && !L_WE) begin
      w_owner_nxt = S_LRD;
    end
    w_burst_nxt = r_burst_cnt;
    if (!F_REQ || w_f_gnt) begin
      w_burst_nxt = 4'd0;
    end else if (w_l_gnt && (r_burst_cnt < LC_MAX)) begin
      w_burst_nxt = r_burst_cnt + 4'd1;
    end
`endif
  end

  // State registers; reset drops any outstanding read
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_owner  <= S_IDLE;
      r_squash <= 1'b0;
      r_m_addr <= '0;
`ifdef IMEM_ARB_LOADER_EN
      r_burst_cnt <= 4'd0;
      r_m_wdata   <= '0;
`endif
    end else begin
      r_owner  <= w_owner_nxt;
      r_squash <= w_squash_nxt;
      if (w_f_gnt || w_l_gnt) begin
        r_m_addr <= M_ADDR;
      end
`ifdef IMEM_ARB_LOADER_EN
      r_burst_cnt <= w_burst_nxt;
      if (w_l_gnt || w_f_gnt) begin
        r_m_wdata <= L_WDATA;
      end
`endif
    end
  end

  // Memory drive and requester-facing outputs; address/data hold when idle
  always_comb begin
    F_GNT    = w_f_gnt;
    L_GNT    = w_l_gnt;
    F_STALL  = F_REQ & ~w_f_gnt;
    M_EN     = w_f_gnt | w_l_gnt;
    M_WE     = 1'b0;
    M_ADDR   = r_m_addr;
    M_WDATA  = '0;
    F_RVALID = 1'b0;
    F_RDATA  = '0;
    L_RVALID = 1'b0;
    L_RDATA  = '0;
    if (w_f_gnt) begin
      M_ADDR = F_ADDR[ADDR_W-1:2];
    end
    if (r_owner == S_FRD) begin
      F_RVALID = ~r_squash & ~ME_BRT;
      F_RDATA  = M_RDATA;
    end
`ifdef IMEM_ARB_LOADER_EN
    M_WDATA = r_m_wdata;
    if (w_l_gnt) begin
      M_ADDR = L_ADDR[ADDR_W-1:2];
      M_WE   = L_WE;
    end
    if (w_l_gnt || w_f_gnt) begin
      M_WDATA = L_WDATA;
    end
    if (r_owner == S_LRD) begin
      L_RVALID = 1'b1;
      L_RDATA  = M_RDATA;
    end
`endif
  end

endmodule

// File: tb/tb_imem_arbiter.sv
// tb_imem_arbiter: vector table plus response scoreboard for imem_arbiter,
// with a behavioural 1-cycle synchronous memory behind the M_* port.
// Covers fetch-only, loader write/read, contention burst, squash and reset.
module tb_imem_arbiter;

  logic        clk;
  logic        rst_n;
  logic        f_req, f_gnt, f_stall, f_rvalid;
  logic [15:0] f_addr;
  logic [31:0] f_rdata;
  logic        me_brt;
  logic        l_req, l_we, l_gnt, l_rvalid;
  logic [15:0] l_addr;
  logic [31:0] l_wdata, l_rdata;
  logic        m_en, m_we;
  logic [13:0] m_addr;
  logic [31:0] m_wdata;
  logic [31:0] m_rdata = 32'h0;

  int checks   = 0;
  int failures = 0;

  imem_arbiter #(.ADDR_W(16), .DATA_W(32), .LD_MAX_BURST(4)) dut (
    .CLK(clk), .RST_N(rst_n),
    .F_REQ(f_req), .F_ADDR(f_addr), .F_GNT(f_gnt), .F_STALL(f_stall),
    .F_RVALID(f_rvalid), .F_RDATA(f_rdata), .ME_BRT(me_brt),
    .L_REQ(l_req), .L_WE(l_we), .L_ADDR(l_addr), .L_WDATA(l_wdata),
    .L_GNT(l_gnt), .L_RVALID(l_rvalid), .L_RDATA(l_rdata),
    .M_EN(m_en), .M_WE(m_we), .M_ADDR(m_addr), .M_WDATA(m_wdata),
    .M_RDATA(m_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: write at the edge ending the grant, read data next cycle
  logic [31:0] mem [0:16383];
  initial begin
    for (int i = 0; i < 16384; i++) mem[i] = 32'h5A000000 | i;
    mem[0] = 32'hDEADBEEF;
    mem[1] = 32'hCAFEBABE;
  end
  always @(posedge clk) begin
    if (m_en) begin
      if (m_we) mem[m_addr] <= m_wdata;
      else      m_rdata     <= mem[m_addr];
    end
  end

  typedef struct {
    logic        f_req;
    logic [15:0] f_addr;
    logic        brt;
    logic        l_req;
    logic        l_we;
    logic [15:0] l_addr;
    logic [31:0] l_wdata;
    logic        e_fg;
    logic        e_lg;
    logic [31:0] e_data;
  } vec_t;

  typedef struct {
    logic        f;
    logic        l;
    logic [31:0] d;
  } rsp_t;

  vec_t vecs[$];
  rsp_t sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic fr, input logic [15:0] fa, input logic brt,
                     input logic lr, input logic we, input logic [15:0] la,
                     input logic [31:0] wd, input logic efg, input logic elg,
                     input logic [31:0] ed);
    vec_t v;
    v.f_req = fr; v.f_addr = fa; v.brt = brt; v.l_req = lr; v.l_we = we;
    v.l_addr = la; v.l_wdata = wd; v.e_fg = efg; v.e_lg = elg; v.e_data = ed;
    vecs.push_back(v);
  endtask

  task automatic idle_inputs();
    f_req = 0; f_addr = 0; me_brt = 0; l_req = 0; l_we = 0; l_addr = 0; l_wdata = 0;
  endtask

  // One cycle: drive, check grant-cycle outputs and the previous response
  task automatic step(input vec_t v);
    rsp_t r;
    rsp_t n;
    logic [13:0] ea;
    @(posedge clk);
    #1;
    f_req = v.f_req; f_addr = v.f_addr; me_brt = v.brt;
    l_req = v.l_req; l_we = v.l_we; l_addr = v.l_addr; l_wdata = v.l_wdata;
    r.f = 0; r.l = 0; r.d = 0;
    if (sb.size() > 0) r = sb.pop_front();
    #4;
    chk("f_gnt", {31'b0, f_gnt}, {31'b0, v.e_fg});
    chk("l_gnt", {31'b0, l_gnt}, {31'b0, v.e_lg});
    chk("f_stall", {31'b0, f_stall}, {31'b0, v.f_req & ~v.e_fg});
    chk("m_en", {31'b0, m_en}, {31'b0, v.e_fg | v.e_lg});
    chk("m_we", {31'b0, m_we}, {31'b0, v.e_lg & v.l_we});
    if (v.e_fg || v.e_lg) begin
      ea = v.e_fg ? v.f_addr[15:2] : v.l_addr[15:2];
      chk("m_addr", {18'b0, m_addr}, {18'b0, ea});
    end
    if (v.e_lg && v.l_we) chk("m_wdata", m_wdata, v.l_wdata);
    chk("f_rvalid", {31'b0, f_rvalid}, {31'b0, r.f & ~v.brt});
    chk("l_rvalid", {31'b0, l_rvalid}, {31'b0, r.l});
    if (r.f && !v.brt) chk("f_rdata", f_rdata, r.d);
    if (r.l)           chk("l_rdata", l_rdata, r.d);
    n.f = v.e_fg & ~v.brt;
    n.l = v.e_lg & ~v.l_we;
    n.d = v.e_data;
    sb.push_back(n);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_f_gnt"},    {31'b0, f_gnt},    32'h0);
    chk({tag, "_f_rvalid"}, {31'b0, f_rvalid}, 32'h0);
    chk({tag, "_l_gnt"},    {31'b0, l_gnt},    32'h0);
    chk({tag, "_l_rvalid"}, {31'b0, l_rvalid}, 32'h0);
    chk({tag, "_m_en"},     {31'b0, m_en},     32'h0);
    chk({tag, "_m_we"},     {31'b0, m_we},     32'h0);
    chk({tag, "_f_rdata"},  f_rdata,           32'h0);
    chk({tag, "_l_rdata"},  l_rdata,           32'h0);
    chk({tag, "_m_addr"},   {18'b0, m_addr},   32'h0);
    chk({tag, "_m_wdata"},  m_wdata,           32'h0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 0;
    idle_inputs();
    sb.delete();
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1;
    rst_n = 1;
  endtask

  vec_t rv;

  initial begin
    rst_n = 0;
    idle_inputs();
    #23;
    chk_all_zero("reset");
    release_reset();

    // Fetch only, then branch squash sequences
    add(1, 16'h0000, 0, 0, 0, 16'h0, 32'h0, 1, 0, 32'hDEADBEEF);
    add(1, 16'h0004, 0, 0, 0, 16'h0, 32'h0, 1, 0, 32'hCAFEBABE);
    add(1, 16'h0008, 0, 0, 0, 16'h0, 32'h0, 1, 0, 32'h5A000002);
    add(1, 16'h000C, 1, 0, 0, 16'h0, 32'h0, 1, 0, 32'h5A000003);
    add(1, 16'h1000, 0, 0, 0, 16'h0, 32'h0, 1, 0, 32'h5A000400);
    add(0, 16'h0000, 0, 0, 0, 16'h0, 32'h0, 0, 0, 32'h0);
`ifdef IMEM_ARB_LOADER_EN
    // Loader write then read-back
    add(0, 16'h0000, 0, 1, 1, 16'h1000, 32'h12345678, 0, 1, 32'h0);
    add(0, 16'h0000, 0, 1, 0, 16'h1000, 32'h0,        0, 1, 32'h12345678);
    add(0, 16'h0000, 0, 0, 0, 16'h0000, 32'h0,        0, 0, 32'h0);
    // Contention: L,L,L,L,F,L,L,L,L,F
    for (int c = 0; c < 10; c++) begin
      if (c == 4 || c == 9) add(1, 16'h0004, 0, 1, 0, 16'h1000, 32'h0, 1, 0, 32'hCAFEBABE);
      else                  add(1, 16'h0004, 0, 1, 0, 16'h1000, 32'h0, 0, 1, 32'h12345678);
    end
    // Fetch drops: burst count clears, loader granted alone
    add(0, 16'h0000, 0, 1, 0, 16'h0004, 32'h0, 0, 1, 32'hCAFEBABE);
    add(0, 16'h0000, 0, 0, 0, 16'h0000, 32'h0, 0, 0, 32'h0);
`else
    // Loader ignored: fetch granted every cycle, no loader grant or write
    for (int c = 0; c < 4; c++)
      add(1, 16'h0004, 0, 1, (c % 2 == 0), 16'h1000, 32'h12345678, 1, 0, 32'hCAFEBABE);
    add(0, 16'h0000, 0, 1, 0, 16'h0000, 32'h0, 0, 0, 32'h0);
    add(0, 16'h0000, 0, 0, 0, 16'h0000, 32'h0, 0, 0, 32'h0);
`endif
    foreach (vecs[i]) step(vecs[i]);

    // Reset while a read is outstanding: its response must never appear
`ifdef IMEM_ARB_LOADER_EN
    rv = '{0, 16'h0, 0, 1, 0, 16'h0000, 32'h0, 0, 1, 32'hDEADBEEF};
`else
    rv = '{1, 16'h0000, 0, 0, 0, 16'h0, 32'h0, 1, 0, 32'hDEADBEEF};
`endif
    step(rv);
    do_reset();
    #4;
    chk_all_zero("midrst");
    release_reset();
    #4;
    chk("post_rst_f_rvalid", {31'b0, f_rvalid}, 32'h0);
    chk("post_rst_l_rvalid", {31'b0, l_rvalid}, 32'h0);
`ifdef IMEM_ARB_LOADER_EN
    rv = '{0, 16'h0, 0, 1, 0, 16'h0004, 32'h0, 0, 1, 32'hCAFEBABE};
`else
    rv = '{1, 16'h0004, 0, 0, 0, 16'h0, 32'h0, 1, 0, 32'hCAFEBABE};
`endif
    step(rv);
    rv = '{0, 16'h0, 0, 0, 0, 16'h0, 32'h0, 0, 0, 32'h0};
    step(rv);
    step(rv);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
